// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: turns the signed motor command into a high-side PWM pin
// plus a direction pin. It applies slew limiting, a dead time before each
// direction change, a non-latching brake cut-off and a latching kill.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   enable       motor drive permitted
//   PWMIn        signed commanded duty (-512..511), sign selects direction
//   brake        rider brake, non-latching cut-off
//   kill         tilt/fault, latching cut-off
//   pwmHigh      PWM pin to gate driver
//   dirOut       0 = forward, 1 = reverse
//   dutyActive   signed duty currently applied
//   periodStrobe one-cycle pulse at each PWM period start
//   fault        high while latched in FAULT
module motor_pwm_driver #(
  parameter int unsigned PRESCALE         = 1,
  parameter int unsigned SLEW_STEP        = 4,
  parameter int unsigned DEADTIME_PERIODS = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic signed [9:0] PWMIn,
  input  logic              brake,
  input  logic              kill,
  output logic              pwmHigh,
  output logic              dirOut,
  output logic signed [9:0] dutyActive,
  output logic              periodStrobe,
  output logic              fault
);

  localparam int unsigned PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DT_W    = $clog2(DEADTIME_PERIODS + 1);
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned MAG_W   = 10;
  localparam int unsigned CNT_MAX = 510;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_FAULT} state_e;

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               strobe_q;
  logic signed [9:0]  duty_q, duty_d;
  logic               dir_q, dir_d;
  logic [DT_W-1:0]    dt_cnt_q, dt_cnt_d;
  logic               pwm_q, pwm_d;
  logic               fault_q, fault_d;

  logic               tick, wrap;
  logic [MAG_W-1:0]   pwm_in_u, tgt_mag, cur_mag, slew_mag, dec_mag;
  logic [MAG_W:0]     up_sum;
  logic               tgt_neg, sign_match, rev_start, dt_last;

  // Free-running timebase; wrap marks the period boundary
  assign tick      = (pre_cnt_q == PRE_W'(PRESCALE - 1));
  assign wrap      = tick && (cnt_q == CNT_W'(CNT_MAX));
  assign pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
  assign cnt_d     = wrap ? '0 : (tick ? cnt_q + CNT_W'(1) : cnt_q);

  // Target magnitude; -512 has no positive counterpart so it clamps to 511
  assign pwm_in_u = PWMIn;
  assign tgt_neg  = PWMIn[9];
  always_comb begin
    tgt_mag = pwm_in_u;
    if (tgt_neg) begin
      tgt_mag = (pwm_in_u == 10'h200) ? 10'd511 : (~pwm_in_u + 10'd1);
    end
  end

  assign cur_mag    = duty_q[9] ? (~duty_q + 10'sd1) : duty_q;
  assign sign_match = (tgt_neg == dir_q);
  assign rev_start  = (tgt_mag != '0) && !sign_match && (cur_mag == '0);
  assign dt_last    = (dt_cnt_q <= DT_W'(1));

  // Move toward target by at most SLEW_STEP without overshoot
  assign up_sum = {1'b0, cur_mag} + (MAG_W+1)'(SLEW_STEP);
  always_comb begin
    slew_mag = cur_mag;
    if (cur_mag < tgt_mag) begin
      slew_mag = (up_sum > {1'b0, tgt_mag}) ? tgt_mag : up_sum[MAG_W-1:0];
    end else if (cur_mag > tgt_mag) begin
      slew_mag = ((cur_mag - tgt_mag) > MAG_W'(SLEW_STEP)) ?
                 (cur_mag - MAG_W'(SLEW_STEP)) : tgt_mag;
    end
  end

  // Wrong direction: wind the magnitude down to zero before reversing
  assign dec_mag = (cur_mag > MAG_W'(SLEW_STEP)) ? (cur_mag - MAG_W'(SLEW_STEP)) : '0;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; kill dominates, then enable
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE:  if (enable) state_d = S_RUN;
        S_RUN: begin
          if (!enable)                          state_d = S_IDLE;
          else if (wrap && !brake && rev_start) state_d = S_DEAD;
        end
        S_DEAD: begin
          if (!enable)             state_d = S_IDLE;
          else if (wrap && dt_last) state_d = S_RUN;
        end
        S_FAULT: if (!enable) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    duty_d   = duty_q;
    dir_d    = dir_q;
    dt_cnt_d = dt_cnt_q;
    fault_d  = (state_d == S_FAULT);
    pwm_d    = (state_q == S_RUN) && enable && !brake && !kill &&
               ({1'b0, cnt_q} < cur_mag);
    case (state_q)
      S_RUN: begin
        if (brake) begin
          duty_d = '0;
        end else if (wrap) begin
          if (rev_start) begin
            duty_d   = '0;
            dt_cnt_d = DT_W'(DEADTIME_PERIODS);
          end else if (sign_match || (tgt_mag == '0)) begin
            duty_d = dir_q ? $signed(~slew_mag + 10'd1) : $signed(slew_mag);
          end else begin
            duty_d = dir_q ? $signed(~dec_mag + 10'd1) : $signed(dec_mag);
          end
        end
      end
      S_DEAD: begin
        duty_d = '0;
        if (wrap) begin
          if (dt_last) begin
            dt_cnt_d = '0;
            dir_d    = ~dir_q;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
          end
        end
      end
      default: duty_d = '0;
    endcase
    // Cut-offs freeze direction and dead-time progress
    if (kill || !enable) begin
      duty_d   = '0;
      dir_d    = dir_q;
      dt_cnt_d = dt_cnt_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      duty_q    <= '0;
      dir_q     <= 1'b0;
      dt_cnt_q  <= '0;
      pwm_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      strobe_q  <= wrap;
      duty_q    <= duty_d;
      dir_q     <= dir_d;
      dt_cnt_q  <= dt_cnt_d;
      pwm_q     <= pwm_d;
      fault_q   <= fault_d;
    end
  end

  assign pwmHigh      = pwm_q;
  assign dirOut       = dir_q;
  assign dutyActive   = duty_q;
  assign periodStrobe = strobe_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: directed bench for motor_pwm_driver. A second instance
// with a full-scale slew step covers the -512 clamp case in parallel.
module tb_motor_pwm_driver;

  logic              clk;
  logic              reset_n;
  logic              enable, brake, kill;
  logic signed [9:0] PWMIn;
  logic              pwmHigh, dirOut, periodStrobe, fault;
  logic signed [9:0] dutyActive;

  logic              enable2;
  logic signed [9:0] PWMIn2;
  logic              pwmHigh2, dirOut2, periodStrobe2, fault2;
  logic signed [9:0] dutyActive2;

  int n_cmp = 0;
  int n_bad = 0;
  int hi, hi2;

  motor_pwm_driver #(.PRESCALE(1), .SLEW_STEP(4), .DEADTIME_PERIODS(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .PWMIn(PWMIn),
    .brake(brake), .kill(kill), .pwmHigh(pwmHigh), .dirOut(dirOut),
    .dutyActive(dutyActive), .periodStrobe(periodStrobe), .fault(fault)
  );

  motor_pwm_driver #(.PRESCALE(1), .SLEW_STEP(511), .DEADTIME_PERIODS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .PWMIn(PWMIn2),
    .brake(1'b0), .kill(1'b0), .pwmHigh(pwmHigh2), .dirOut(dirOut2),
    .dutyActive(dutyActive2), .periodStrobe(periodStrobe2), .fault(fault2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!periodStrobe && n < 600);
    if (!periodStrobe) check("strobe_timeout", periodStrobe, 1);
  endtask

  // Counts pwm-high cycles over the next 511 cycles, ending on a boundary
  task automatic measure_period(output int h, output int h2);
    int st;
    h = 0; h2 = 0; st = 0;
    for (int i = 0; i < 511; i++) begin
      @(negedge clk);
      h  += int'(pwmHigh);
      h2 += int'(pwmHigh2);
      st += int'(periodStrobe);
    end
    check("strobe_count", st, 1);
    check("strobe_at_511", periodStrobe, 1);
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b0; brake = 1'b0; kill = 1'b0; PWMIn = '0;
    enable2 = 1'b0; PWMIn2 = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", pwmHigh, 0);
    check("rst_dir", dirOut, 0);
    check("rst_duty", dutyActive, 0);
    check("rst_strobe", periodStrobe, 0);
    check("rst_fault", fault, 0);

    // Ramp to +100 while the second instance goes to full reverse
    reset_n = 1'b1;
    enable = 1'b1; PWMIn = 10'sd100;
    enable2 = 1'b1; PWMIn2 = -10'sd512;
    for (int k = 1; k <= 25; k++) begin
      wait_boundary();
      check("ramp_up", dutyActive, 4 * k);
      if (k == 1) check("clamp_dead_duty", dutyActive2, 0);
      if (k == 3) check("clamp_dir", dirOut2, 1);
      if (k == 4) check("clamp_duty", dutyActive2, -511);
    end
    measure_period(hi, hi2);
    check("pwm_high_100", hi, 100);
    check("clamp_pwm_full", hi2, 511);
    check("ramp_settled", dutyActive, 100);

    // Kill pulse mid-period
    repeat (50) @(negedge clk);
    check("pre_kill_pwm", pwmHigh, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_fault", fault, 1);
    check("kill_pwm", pwmHigh, 0);
    check("kill_duty", dutyActive, 0);
    repeat (5) @(negedge clk);
    check("fault_latched", fault, 1);
    check("fault_duty", dutyActive, 0);
    enable = 1'b0;
    @(negedge clk);
    check("fault_clear", fault, 0);

    // Re-enable ramps from zero to +20
    enable = 1'b1; PWMIn = 10'sd20;
    for (int k = 1; k <= 5; k++) begin
      wait_boundary();
      check("reramp", dutyActive, 4 * k);
    end

    // Reversal to -20 with dead time
    PWMIn = -10'sd20;
    for (int k = 1; k <= 5; k++) begin
      wait_boundary();
      check("rev_down", dutyActive, 20 - 4 * k);
    end
    wait_boundary();
    check("dead_duty", dutyActive, 0);
    check("dead_dir", dirOut, 0);
    measure_period(hi, hi2);
    check("dead1_pwm", hi, 0);
    check("dead1_dir", dirOut, 0);
    measure_period(hi, hi2);
    check("dead2_pwm", hi, 0);
    check("rev_dir", dirOut, 1);
    check("rev_zero", dutyActive, 0);
    for (int k = 1; k <= 5; k++) begin
      wait_boundary();
      check("rev_ramp", dutyActive, -4 * k);
    end

    // Brake mid-period
    repeat (10) @(negedge clk);
    check("pre_brake_pwm", pwmHigh, 1);
    brake = 1'b1;
    @(negedge clk);
    check("brake_pwm", pwmHigh, 0);
    check("brake_duty", dutyActive, 0);
    repeat (3) @(negedge clk);
    brake = 1'b0;
    wait_boundary();
    check("brake_release", dutyActive, -4);

    // Enable drop keeps direction
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_duty", dutyActive, 0);
    check("en_drop_dir", dirOut, 1);
    enable = 1'b1;
    wait_boundary();
    check("reenable_duty", dutyActive, -4);

    // Asynchronous reset with pwmHigh asserted
    repeat (2) @(negedge clk);
    check("pre_rst_pwm", pwmHigh, 1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_pwm", pwmHigh, 0);
    check("arst_duty", dutyActive, 0);
    check("arst_dir", dirOut, 0);
    check("arst_fault", fault, 0);
    check("arst_pwm2", pwmHigh2, 0);
    check("arst_dir2", dirOut2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
